// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-side coherence client: bus word, MSI state and FSM encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } client_state_t;

  typedef enum logic {
    SNP_IDLE = 1'b0,
    SNP_ACT  = 1'b1
  } snoop_state_t;

  // True when a and b fall in the same block; lsb is log2 of the block size in bytes.
  function automatic logic same_block(input word_t a, input word_t b, input int unsigned lsb);
    return ((a ^ b) >> lsb) == 32'd0;
  endfunction

endpackage

// File: rtl/coherence_client_snoop_responder.sv
// Snoop side of the coherence client: tracks a snoop from ccwait rise to fall, picks the
// supply source and muxes dstore/ccwrite between the snoop answer and the miss FSM.
module snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int  BLOCK_WORDS = 2,
  localparam int WW          = $clog2(BLOCK_WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ccwait,
  input  logic          ccinv,
  input  logic [31:0]   ccsnoopaddr,
  input  logic          probe_hit,
  input  logic          probe_mod,
  input  logic [31:0]   probe_data,
  input  logic [31:0]   wb_data,
  input  logic          in_wb,
  input  logic          in_rd,
  input  logic [31:0]   wb_addr,
  input  logic [31:0]   miss_addr,
  input  logic          dwait,
  input  logic [31:0]   miss_dstore,
  input  logic          miss_ccwrite,
  output logic [31:0]   dstore,
  output logic          ccwrite,
  output logic          snp_upd,
  output logic          snp_inv,
  output logic          victim_sel,
  output logic [WW-1:0] snp_idx,
  output logic          snp_state
);

  snoop_state_t state_q, state_d;
  logic         hit_q, inv_q;
  logic         victim_match, rd_match, act, supply;

  // A block still being filled is not valid yet, so a snoop to it must answer miss.
  assign victim_match = in_wb && same_block(ccsnoopaddr, wb_addr, WW + 2);
  assign rd_match     = in_rd && same_block(ccsnoopaddr, miss_addr, WW + 2);
  assign act          = (state_q == SNP_ACT) && ccwait;
  assign supply       = act && (victim_match || (probe_hit && probe_mod && !rd_match));
  assign victim_sel   = act && victim_match && dwait;
  assign snp_idx      = ccsnoopaddr[WW+1:2];
  assign snp_state    = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SNP_IDLE;
      hit_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ccwait) begin
        hit_q <= probe_hit && !rd_match;
        inv_q <= ccinv;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    snp_upd = 1'b0;
    snp_inv = 1'b0;
    ccwrite = act ? supply : miss_ccwrite;
    dstore  = miss_dstore;
    // The victim word reaches wb_data through the word_idx override while victim_sel is set.
    if (supply) begin
      if (victim_match) begin
        if (dwait) dstore = wb_data;
      end else if (!in_wb || dwait) begin
        dstore = probe_data;
      end
    end
    case (state_q)
      SNP_IDLE: if (ccwait) state_d = SNP_ACT;
      SNP_ACT: begin
        if (!ccwait) begin
          state_d = SNP_IDLE;
          snp_upd = hit_q;
          snp_inv = hit_q && inv_q;
        end
      end
      default: state_d = SNP_IDLE;
    endcase
  end

endmodule

// File: rtl/coherence_client.sv
// Per-core coherence client: miss FSM (victim writeback, then BusRd/BusRdX fill) with its
// word counter, plus the snoop responder answering memory_control snoops in parallel.
module coherence_client
  import cpu_types_pkg::*;
#(
  parameter int  CPUID       = 0,
  parameter int  BLOCK_WORDS = 2,
  localparam int WW          = $clog2(BLOCK_WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          miss_req,
  input  logic [31:0]   miss_addr,
  input  logic          miss_excl,
  input  logic          wb_needed,
  input  logic [31:0]   wb_addr,
  input  logic [31:0]   wb_data,
  output logic [WW-1:0] word_idx,
  output logic          fill_we,
  output logic [31:0]   fill_data,
  output logic          miss_done,
  output logic [31:0]   probe_addr,
  input  logic          probe_hit,
  input  logic          probe_mod,
  input  logic [31:0]   probe_data,
  output logic          snp_upd,
  output logic          snp_inv,
  output logic          dREN,
  output logic          dWEN,
  output logic [31:0]   daddr,
  output logic [31:0]   dstore,
  input  logic [31:0]   dload,
  input  logic          dwait,
  output logic          cctrans,
  output logic          ccwrite,
  input  logic          ccwait,
  input  logic          ccinv,
  input  logic [31:0]   ccsnoopaddr,
  output logic [1:0]    client_state,
  output logic          snoop_state
);

  // Handshake: a bus word is requested while dREN/dWEN is high with daddr/dstore held
  // stable; it completes in the cycle memory_control drives dwait low.
  client_state_t state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [31:0]   miss_addr_q, wb_addr_q;
  logic          excl_q;
  logic [31:0]   offset;
  logic          last_word;
  logic [31:0]   miss_dstore;
  logic          miss_ccwrite;
  logic          victim_sel;
  logic [WW-1:0] snp_idx;

  assign offset       = {{(30 - WW){1'b0}}, cnt_q, 2'b00};
  assign last_word    = (cnt_q == WW'(BLOCK_WORDS - 1));
  assign fill_data    = dload;
  assign probe_addr   = ccsnoopaddr;
  assign word_idx     = victim_sel ? snp_idx : cnt_q;
  assign client_state = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      excl_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && miss_req) begin
        miss_addr_q <= miss_addr;
        wb_addr_q   <= wb_addr;
        excl_q      <= miss_excl;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    fill_we      = 1'b0;
    miss_done    = 1'b0;
    cctrans      = 1'b0;
    miss_ccwrite = 1'b0;
    miss_dstore  = '0;
    case (state_q)
      IDLE: if (miss_req) state_d = wb_needed ? WB : RD;
      WB: begin
        dWEN        = 1'b1;
        cctrans     = 1'b1;
        daddr       = wb_addr_q + offset;
        miss_dstore = wb_data;
        if (!dwait) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = RD;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
      end
      RD: begin
        dREN         = 1'b1;
        cctrans      = 1'b1;
        daddr        = miss_addr_q + offset;
        miss_ccwrite = excl_q;
        fill_we      = !dwait;
        if (!dwait) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
      end
      DONE: begin
        miss_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  snoop_responder #(.BLOCK_WORDS(BLOCK_WORDS)) u_snoop (
    .CLK          (CLK),
    .RST          (RST),
    .ccwait       (ccwait),
    .ccinv        (ccinv),
    .ccsnoopaddr  (ccsnoopaddr),
    .probe_hit    (probe_hit),
    .probe_mod    (probe_mod),
    .probe_data   (probe_data),
    .wb_data      (wb_data),
    .in_wb        (state_q == WB),
    .in_rd        (state_q == RD),
    .wb_addr      (wb_addr_q),
    .miss_addr    (miss_addr_q),
    .dwait        (dwait),
    .miss_dstore  (miss_dstore),
    .miss_ccwrite (miss_ccwrite),
    .dstore       (dstore),
    .ccwrite      (ccwrite),
    .snp_upd      (snp_upd),
    .snp_inv      (snp_inv),
    .victim_sel   (victim_sel),
    .snp_idx      (snp_idx),
    .snp_state    (snoop_state)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(dREN && dWEN))
        else $error("coherence_client%0d: dREN and dWEN both high", CPUID);
    end
  end

endmodule

// File: tb/tb_coherence_client.sv
// Directed bench for coherence_client: per-cycle vector table over several miss/snoop
// scenarios, plus hand-written reset sequences.
module tb_coherence_client;

  typedef struct {
    logic [31:0] miss_addr;
    logic        excl;
    logic        wb_needed;
    logic [31:0] wb_addr;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        ccinv;
    logic        hit;
    logic        mod;
    logic [31:0] pdata;
  } cfg_t;

  typedef struct {
    int          sc;
    logic        mreq;
    logic        dwait;
    logic        ccwait;
    logic [31:0] saddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        we;
    logic        idx;
    logic        done;
    logic        ctrans;
    logic        cwrite;
    logic        upd;
    logic        inv;
  } vec_t;

  logic        CLK, RST;
  logic        miss_req, miss_excl, wb_needed;
  logic [31:0] miss_addr, wb_addr, wb_data;
  logic        word_idx;
  logic        fill_we, miss_done;
  logic [31:0] fill_data, probe_addr;
  logic        probe_hit, probe_mod;
  logic [31:0] probe_data;
  logic        snp_upd, snp_inv;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;
  logic [1:0]  client_state;
  logic        snoop_state;

  int   n_cmp = 0;
  int   n_bad = 0;
  cfg_t cfgs[8];
  cfg_t cur;
  vec_t vecs[$];

  coherence_client #(.CPUID(0), .BLOCK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_excl(miss_excl),
    .wb_needed(wb_needed), .wb_addr(wb_addr), .wb_data(wb_data),
    .word_idx(word_idx), .fill_we(fill_we), .fill_data(fill_data), .miss_done(miss_done),
    .probe_addr(probe_addr), .probe_hit(probe_hit), .probe_mod(probe_mod),
    .probe_data(probe_data), .snp_upd(snp_upd), .snp_inv(snp_inv),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload),
    .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .client_state(client_state), .snoop_state(snoop_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cache model: victim word selected by word_idx.
  always_comb wb_data = word_idx ? cur.v1 : cur.v0;

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  function automatic vec_t v(input int sc, input logic mreq, input logic dw, input logic cw,
                             input logic [31:0] sa, input logic ren, input logic wen,
                             input logic [31:0] ad, input logic [31:0] st, input logic we,
                             input logic idx, input logic dn, input logic ct, input logic cwr,
                             input logic up, input logic iv);
    vec_t r;
    r.sc = sc; r.mreq = mreq; r.dwait = dw; r.ccwait = cw; r.saddr = sa;
    r.dren = ren; r.dwen = wen; r.daddr = ad; r.dstore = st; r.we = we; r.idx = idx;
    r.done = dn; r.ctrans = ct; r.cwrite = cwr; r.upd = up; r.inv = iv;
    return r;
  endfunction

  // driver tasks
  task automatic drive_cfg(input int sc);
    cur        = cfgs[sc];
    miss_addr  = cur.miss_addr;
    miss_excl  = cur.excl;
    wb_needed  = cur.wb_needed;
    wb_addr    = cur.wb_addr;
    ccinv      = cur.ccinv;
    probe_hit  = cur.hit;
    probe_mod  = cur.mod;
    probe_data = cur.pdata;
  endtask

  task automatic apply(input vec_t e, input int i);
    drive_cfg(e.sc);
    miss_req    = e.mreq;
    dwait       = e.dwait;
    ccwait      = e.ccwait;
    ccsnoopaddr = e.saddr;
    dload       = 32'hF000_0000 + i;
  endtask

  task automatic compare(input vec_t e, input int i);
    check("dREN",       i, 32'(dREN),      32'(e.dren));
    check("dWEN",       i, 32'(dWEN),      32'(e.dwen));
    check("daddr",      i, daddr,          e.daddr);
    check("dstore",     i, dstore,         e.dstore);
    check("fill_we",    i, 32'(fill_we),   32'(e.we));
    check("word_idx",   i, 32'(word_idx),  32'(e.idx));
    check("miss_done",  i, 32'(miss_done), 32'(e.done));
    check("cctrans",    i, 32'(cctrans),   32'(e.ctrans));
    check("ccwrite",    i, 32'(ccwrite),   32'(e.cwrite));
    check("snp_upd",    i, 32'(snp_upd),   32'(e.upd));
    check("snp_inv",    i, 32'(snp_inv),   32'(e.inv));
    check("probe_addr", i, probe_addr,     e.saddr);
    check("fill_data",  i, fill_data,      32'hF000_0000 + i);
  endtask

  initial begin
    //           miss_addr     excl wbn  wb_addr       v0             v1             inv  hit  mod  pdata
    cfgs[0] = '{32'h100, 1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    cfgs[1] = '{32'h300, 1'b0, 1'b1, 32'h200, 32'hAAAA_0000, 32'hAAAA_0004, 1'b0, 1'b0, 1'b0, 32'h0};
    cfgs[2] = '{32'h600, 1'b1, 1'b1, 32'h500, 32'hBBBB_0000, 32'hBBBB_0004, 1'b0, 1'b0, 1'b0, 32'h0};
    cfgs[3] = '{32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    cfgs[4] = '{32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b1, 1'b1, 1'b1, 32'hCAFE_F00D};
    cfgs[5] = '{32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h1234_5678};
    cfgs[6] = '{32'h300, 1'b0, 1'b1, 32'h200, 32'hAAAA_0000, 32'hAAAA_0004, 1'b0, 1'b1, 1'b1, 32'h1111_1111};
    cfgs[7] = '{32'h700, 1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h2222_2222};

    // clean read miss, two cycles per word
    vecs.push_back(v(0,1,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,0,     1,0,32'h100,0,0,0,0,1,0,0,0));
    vecs.push_back(v(0,1,0,0,0,     1,0,32'h100,0,1,0,0,1,0,0,0));
    vecs.push_back(v(0,1,1,0,0,     1,0,32'h104,0,0,1,0,1,0,0,0));
    vecs.push_back(v(0,1,0,0,0,     1,0,32'h104,0,1,1,0,1,0,0,0));
    vecs.push_back(v(0,1,1,0,0,     0,0,0,0,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    // dirty victim writeback then fill
    vecs.push_back(v(1,1,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(1,1,1,0,0,     0,1,32'h200,32'hAAAA_0000,0,0,0,1,0,0,0));
    vecs.push_back(v(1,1,0,0,0,     0,1,32'h200,32'hAAAA_0000,0,0,0,1,0,0,0));
    vecs.push_back(v(1,1,0,0,0,     0,1,32'h204,32'hAAAA_0004,0,1,0,1,0,0,0));
    vecs.push_back(v(1,1,0,0,0,     1,0,32'h300,0,1,0,0,1,0,0,0));
    vecs.push_back(v(1,1,0,0,0,     1,0,32'h304,0,1,1,0,1,0,0,0));
    vecs.push_back(v(1,1,1,0,0,     0,0,0,0,0,0,1,0,0,0,0));
    vecs.push_back(v(1,0,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    // exclusive fill after writeback: ccwrite only in RD
    vecs.push_back(v(2,1,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(2,1,0,0,0,     0,1,32'h500,32'hBBBB_0000,0,0,0,1,0,0,0));
    vecs.push_back(v(2,1,0,0,0,     0,1,32'h504,32'hBBBB_0004,0,1,0,1,0,0,0));
    vecs.push_back(v(2,1,1,0,0,     1,0,32'h600,0,0,0,0,1,1,0,0));
    vecs.push_back(v(2,1,0,0,0,     1,0,32'h600,0,1,0,0,1,1,0,0));
    vecs.push_back(v(2,1,1,0,0,     1,0,32'h604,0,0,1,0,1,1,0,0));
    vecs.push_back(v(2,1,0,0,0,     1,0,32'h604,0,1,1,0,1,1,0,0));
    vecs.push_back(v(2,1,1,0,0,     0,0,0,0,0,0,1,0,0,0,0));
    vecs.push_back(v(2,0,1,0,0,     0,0,0,0,0,0,0,0,0,0,0));
    // snoop to Modified block, no invalidate
    vecs.push_back(v(3,0,1,1,32'h404, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(3,0,1,1,32'h404, 0,0,0,32'hDEAD_BEEF,0,0,0,0,1,0,0));
    vecs.push_back(v(3,0,1,0,32'h404, 0,0,0,0,0,0,0,0,0,1,0));
    vecs.push_back(v(3,0,1,0,32'h404, 0,0,0,0,0,0,0,0,0,0,0));
    // snoop to Modified block with invalidate
    vecs.push_back(v(4,0,1,1,32'h408, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(4,0,1,1,32'h408, 0,0,0,32'hCAFE_F00D,0,0,0,0,1,0,0));
    vecs.push_back(v(4,0,1,0,32'h408, 0,0,0,0,0,0,0,0,0,1,1));
    vecs.push_back(v(4,0,1,0,32'h408, 0,0,0,0,0,0,0,0,0,0,0));
    // snoop that misses: no supply, no update
    vecs.push_back(v(5,0,1,1,32'h410, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(5,0,1,1,32'h410, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(5,0,1,0,32'h410, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(5,0,1,0,32'h410, 0,0,0,0,0,0,0,0,0,0,0));
    // snoop to victim word 1 while own WB waits, raised together with miss_req
    vecs.push_back(v(6,1,1,1,32'h204, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(6,1,1,1,32'h204, 0,1,32'h200,32'hAAAA_0004,0,1,0,1,1,0,0));
    vecs.push_back(v(6,1,1,0,32'h204, 0,1,32'h200,32'hAAAA_0000,0,0,0,1,0,1,0));
    vecs.push_back(v(6,1,0,0,32'h204, 0,1,32'h200,32'hAAAA_0000,0,0,0,1,0,0,0));
    vecs.push_back(v(6,1,0,0,32'h204, 0,1,32'h204,32'hAAAA_0004,0,1,0,1,0,0,0));
    vecs.push_back(v(6,1,0,0,32'h204, 1,0,32'h300,0,1,0,0,1,0,0,0));
    vecs.push_back(v(6,1,0,0,32'h204, 1,0,32'h304,0,1,1,0,1,0,0,0));
    vecs.push_back(v(6,1,1,0,32'h204, 0,0,0,0,0,0,1,0,0,0,0));
    vecs.push_back(v(6,0,1,0,32'h204, 0,0,0,0,0,0,0,0,0,0,0));
    // snoop to the block being filled answers miss despite stale probe_mod
    vecs.push_back(v(7,1,1,0,32'h704, 0,0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(7,1,1,1,32'h704, 1,0,32'h700,0,0,0,0,1,0,0,0));
    vecs.push_back(v(7,1,1,1,32'h704, 1,0,32'h700,0,0,0,0,1,0,0,0));
    vecs.push_back(v(7,1,1,0,32'h704, 1,0,32'h700,0,0,0,0,1,0,0,0));
    vecs.push_back(v(7,1,0,0,32'h704, 1,0,32'h700,0,1,0,0,1,0,0,0));
    vecs.push_back(v(7,1,0,0,32'h704, 1,0,32'h704,0,1,1,0,1,0,0,0));
    vecs.push_back(v(7,1,1,0,32'h704, 0,0,0,0,0,0,1,0,0,0,0));
    vecs.push_back(v(7,0,1,0,32'h704, 0,0,0,0,0,0,0,0,0,0,0));

    // reset state
    RST = 1'b1;
    drive_cfg(0);
    miss_req = 1'b0; dwait = 1'b1; ccwait = 1'b0; ccsnoopaddr = '0; dload = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_dREN",    900, 32'(dREN),      0);
    check("rst_dWEN",    900, 32'(dWEN),      0);
    check("rst_cctrans", 900, 32'(cctrans),   0);
    check("rst_ccwrite", 900, 32'(ccwrite),   0);
    check("rst_done",    900, 32'(miss_done), 0);
    check("rst_idx",     900, 32'(word_idx),  0);
    check("rst_daddr",   900, daddr,          0);
    check("rst_state",   900, 32'(client_state), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      @(negedge CLK);
      compare(vecs[i], i);
      @(posedge CLK); #1;
    end

    // reset during RD word 1 aborts the miss
    drive_cfg(0);
    miss_req = 1'b1; dwait = 1'b1; ccwait = 1'b0; ccsnoopaddr = '0;
    @(posedge CLK); #1;
    dwait = 1'b0;
    @(posedge CLK); #1;
    dwait = 1'b1; RST = 1'b1;
    @(negedge CLK);
    check("pre_rst_idx",  901, 32'(word_idx), 1);
    check("pre_rst_dREN", 901, 32'(dREN),     1);
    check("pre_rst_addr", 901, daddr,         32'h104);
    @(posedge CLK); #1;
    RST = 1'b0; miss_req = 1'b0;
    @(negedge CLK);
    check("mid_rst_dREN",    902, 32'(dREN),         0);
    check("mid_rst_cctrans", 902, 32'(cctrans),      0);
    check("mid_rst_idx",     902, 32'(word_idx),     0);
    check("mid_rst_state",   902, 32'(client_state), 0);
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_done", 903 + k, 32'(miss_done), 0);
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
